regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  - Shares the single register-file write port (write_reg/target_reg/write_rd_data) between two
//    writeback requesters: ALU and LSU.
//  - Uses fixed priority with a starvation guard. Output is registered, one cycle of latency.
//  - Optional post-reset sweep initialises x1..x31 before any writeback is accepted.
//  - Sits between the execute/memory stages and reg_file in the multi-cycle core.
// PARAMETERS
//  XLEN          32   data width of write_rd_data and the requester data buses
//  STARVE_LIMIT  4    consecutive cycles an ALU request may lose before it is forced to win
//  SP_INIT       128  value written to x2 (sp) by the clear sweep
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     synchronous reset, active-high
//  alu_valid      in   1     ALU writeback request
//  alu_rd         in   5     ALU destination register
//  alu_data       in   XLEN  ALU result
//  alu_ready      out  1     ALU request accepted this cycle (combinational)
//  lsu_valid      in   1     LSU writeback request
//  lsu_rd         in   5     LSU destination register
//  lsu_data       in   XLEN  LSU load data
//  lsu_ready      out  1     LSU request accepted this cycle (combinational)
//  write_reg      out  1     reg_file write enable (registered)
//  target_reg     out  5     reg_file write address (registered)
//  write_rd_data  out  XLEN  reg_file write data (registered)
//  busy           out  1     clear sweep in progress; all readys held at 0
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): write_reg=0, target_reg=0, write_rd_data=0, starve_cnt=0.
//    - With the macro: state=CLEAR, sweep_idx=1.
//    - Without it: state=ARB.
//  - Readys are 0 in every cycle with rst=1 or state=CLEAR.
//  - A transfer happens when valid && ready. Readys are derived from the current valids only;
//    requesters must hold valid, rd and data until ready.
//  - ARB grant rule, evaluated each cycle:
//    - Only one valid: that requester gets ready=1.
//    - Both valid: LSU wins, unless starve_cnt == STARVE_LIMIT, in which case ALU wins.
//    - starve_cnt increments when ALU is valid and loses; it clears when ALU wins or
//      alu_valid=0. It saturates at STARVE_LIMIT.
//  - Latency: a transfer in cycle N drives write_reg=1, target_reg=rd and write_rd_data=data in
//    cycle N+1. reg_file captures the write at the end of N+1.
//  - rd == 0: the request is accepted (ready=1) but write_reg=0 next cycle (x0 write dropped).
//  - No transfer in a cycle: write_reg=0 next cycle. target_reg and write_rd_data hold their
//    previous values.
//  - Both requesters with the same rd: the winner is written first and the loser one cycle
//    later, so the loser's value persists. Program ordering is the issuing stage's job.
//  - No reordering and no buffering: at most one write per cycle, full throughput.
//  - Reset mid-sweep restarts the sweep at index 1.
//  - A request pending at reset is discarded and must be re-presented after reset.
// CONFIGURATION
//  REGFILE_CLEAR_EN defined:
//    - CLEAR state: one write per cycle for sweep_idx = 1..31.
//    - Each write: write_reg=1, target_reg=sweep_idx, write_rd_data = 0, except
//      SP_INIT when sweep_idx==2.
//    - busy=1 from reset through the cycle carrying the x31 write. ARB is entered the next cycle.
//    - Total 31 sweep cycles after reset deasserts.
//  REGFILE_CLEAR_EN undefined:
//    - No CLEAR state; the sweep counter is not instantiated.
//    - busy tied to 0. ARB is active in the first cycle after reset.
// TESTING
//  1. CLEAR_EN on, release rst:
//     -> 31 consecutive writes x1..x31, x2=128, others 0; busy falls after x31; readys 0 meanwhile.
//  2. alu_valid=1, rd=5, data=32'hDEAD_BEEF, lsu idle:
//     -> alu_ready=1 same cycle; next cycle write_reg=1, target_reg=5, data=DEADBEEF.
//  3. Both valid continuously, STARVE_LIMIT=4:
//     -> grant sequence LSU,LSU,LSU,LSU,ALU then repeats; write_reg=1 every cycle.
//  4. lsu_valid=1 with rd=0, data=32'h1234:
//     -> lsu_ready=1; next cycle write_reg=0.
//  5. rst asserted at sweep index 10:
//     -> outputs reset that cycle; sweep restarts at x1 and again issues all 31 writes.
//  6. CLEAR_EN off, request in the first cycle after reset:
//     -> ready=1 immediately; busy=0 throughout.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle shared by the writeback arbiter and its neighbours.
// Signals:
//   alu_valid/alu_rd/alu_data/alu_ready : ALU writeback request channel
//   lsu_valid/lsu_rd/lsu_data/lsu_ready : LSU writeback request channel
//   write_reg/target_reg/write_rd_data  : reg_file write port (registered)
//   busy                                : post-reset clear sweep in progress
// The slave modport is the arbiter. The master modport is the requester/reg_file side.
interface regfile_wb_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            lsu_valid;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;
    logic            write_reg;
    logic [4:0]      target_reg;
    logic [XLEN-1:0] write_rd_data;
    logic            busy;

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready, write_reg, target_reg, write_rd_data, busy
    );

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready, write_reg, target_reg, write_rd_data, busy
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the single reg_file write port between the ALU and LSU writeback requesters.
// LSU has fixed priority. An ALU request that keeps losing is forced to win once it has
// lost STARVE_LIMIT consecutive cycles. The write port is registered (one cycle latency).
// Writes to x0 are accepted but never reach reg_file.
//
// Optional feature macro: REGFILE_CLEAR_EN. When it is defined, a sweep after reset writes
// x1..x31 (x2 gets SP_INIT, the rest get 0) before any request is accepted. busy is high
// for the whole sweep.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   bus : regfile_wb_arbiter_if.slave (request channels, write port, busy)
module regfile_wb_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned SP_INIT      = 128
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

    logic            write_q, write_d;
    logic [4:0]      target_q, target_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [CntW-1:0] starve_q, starve_d;

    logic arb_active;
    logic alu_grant;
    logic lsu_grant;

`ifdef REGFILE_CLEAR_EN
    typedef enum logic [0:0] {StClear, StArb} state_e;

    state_e     state_q, state_d;
    // Counts 1..32; the value 32 is one extra busy cycle so busy covers the cycle in which
    // the registered x31 write is visible.
    logic [5:0] sweep_q, sweep_d;

    assign arb_active = !rst && (state_q == StArb);
    assign bus.busy   = (state_q == StClear);
`else
    assign arb_active = !rst;
    assign bus.busy   = 1'b0;
`endif

    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (arb_active) begin
            alu_grant = bus.alu_valid && (!bus.lsu_valid || (starve_q == StarveMax));
            lsu_grant = bus.lsu_valid && !alu_grant;
        end
    end

    assign bus.alu_ready = alu_grant;
    assign bus.lsu_ready = lsu_grant;

    always_comb begin
        // ALU losing only happens when LSU was granted over it.
        starve_d = '0;
        if (bus.alu_valid && lsu_grant) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
        end

        write_d  = 1'b0;
        target_d = target_q;
        data_d   = data_q;
        if (alu_grant) begin
            write_d  = (bus.alu_rd != 5'd0);
            target_d = bus.alu_rd;
            data_d   = bus.alu_data;
        end else if (lsu_grant) begin
            write_d  = (bus.lsu_rd != 5'd0);
            target_d = bus.lsu_rd;
            data_d   = bus.lsu_data;
        end

`ifdef REGFILE_CLEAR_EN
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == StClear) begin
            if (!sweep_q[5]) begin
                write_d  = 1'b1;
                target_d = sweep_q[4:0];
                data_d   = (sweep_q == 6'd2) ? XLEN'(SP_INIT) : '0;
                sweep_d  = sweep_q + 6'd1;
            end else begin
                state_d = StArb;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q  <= 1'b0;
            target_q <= 5'd0;
            data_q   <= '0;
            starve_q <= '0;
`ifdef REGFILE_CLEAR_EN
            state_q  <= StClear;
            sweep_q  <= 6'd1;
`endif
        end else begin
            write_q  <= write_d;
            target_q <= target_d;
            data_q   <= data_d;
            starve_q <= starve_d;
`ifdef REGFILE_CLEAR_EN
            state_q  <= state_d;
            sweep_q  <= sweep_d;
`endif
        end
    end

    assign bus.write_reg     = write_q;
    assign bus.target_reg    = target_q;
    assign bus.write_rd_data = data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned SP_INIT      = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_wb_arbiter_if #(.XLEN(XLEN)) bus ();

    regfile_wb_arbiter #(
        .XLEN        (XLEN),
        .STARVE_LIMIT(STARVE_LIMIT),
        .SP_INIT     (SP_INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: consecutive ALU losses and the expected write port.
    int unsigned     losses;
    bit              exp_wr;
    logic [4:0]      exp_tgt;
    logic [XLEN-1:0] exp_dat;
    bit              td_known;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge. Holds rst for the given cycles, checks readys and reset values.
    task automatic apply_reset(input int cycles);
        rst           = 1'b1;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = $urandom;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd4;
        bus.lsu_data  = $urandom;
        for (int i = 0; i < cycles; i++) begin
            #1;
            check_eq("rst_alu_ready", bus.alu_ready, 0);
            check_eq("rst_lsu_ready", bus.lsu_ready, 0);
            @(negedge clk);
        end
        check_eq("rst_write_reg", bus.write_reg, 0);
        check_eq("rst_target_reg", bus.target_reg, 0);
        check_eq("rst_write_data", bus.write_rd_data, 0);
        rst           = 1'b0;
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        losses        = 0;
        exp_wr        = 1'b0;
        exp_tgt       = 5'd0;
        exp_dat       = '0;
        td_known      = 1'b1;
    endtask

    // Follows reset release. stop_at != 0 returns right after write x<stop_at> is seen.
    task automatic run_sweep(input int stop_at);
        for (int k = 0; k < 32; k++) begin
            bus.alu_valid = 1'b1;
            bus.lsu_valid = 1'b1;
            #1;
            check_eq("sweep_alu_ready", bus.alu_ready, 0);
            check_eq("sweep_lsu_ready", bus.lsu_ready, 0);
            check_eq("sweep_busy", bus.busy, 1);
            @(negedge clk);
            if (k < 31) begin
                check_eq("sweep_write_reg", bus.write_reg, 1);
                check_eq("sweep_target", bus.target_reg, k + 1);
                check_eq("sweep_data", bus.write_rd_data, (k + 1 == 2) ? SP_INIT : 0);
                if (stop_at != 0 && k + 1 == stop_at) return;
            end
        end
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        check_eq("sweep_busy_end", bus.busy, 0);
        check_eq("sweep_write_end", bus.write_reg, 0);
        exp_tgt  = 5'd31;
        exp_dat  = '0;
        td_known = 1'b1;
    endtask

    // One arbitrated cycle: drive at a falling edge, check readys, then the write one cycle on.
    task automatic step(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                        output bit ag, output bit lg, output bit got_a, output bit got_l);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ld;
        #1;
        if (av && lv) begin
            ag = (losses == STARVE_LIMIT);
            lg = !ag;
        end else begin
            ag = av;
            lg = lv;
        end
        got_a = bus.alu_ready;
        got_l = bus.lsu_ready;
        check_eq("alu_ready", got_a, ag);
        check_eq("lsu_ready", got_l, lg);
        check_eq("busy", bus.busy, 0);
        if (av && !ag) losses = (losses < STARVE_LIMIT) ? losses + 1 : losses;
        else losses = 0;
        exp_wr = 1'b0;
        if (ag || lg) begin
            exp_wr = ag ? (ard != 0) : (lrd != 0);
            if (exp_wr) begin
                exp_tgt  = ag ? ard : lrd;
                exp_dat  = ag ? ad : ld;
                td_known = 1'b1;
            end else begin
                td_known = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("write_reg", bus.write_reg, exp_wr);
        if (td_known) begin
            check_eq("target_reg", bus.target_reg, exp_tgt);
            check_eq("write_data", bus.write_rd_data, exp_dat);
        end
    endtask

    initial begin
        bit              ag, lg, ga, gl;
        bit              ap, lp;
        logic [4:0]      ard, lrd;
        logic [XLEN-1:0] ad, ld;

        @(negedge clk);
        apply_reset(2);
`ifdef REGFILE_CLEAR_EN
        run_sweep(0);
        apply_reset(1);
        run_sweep(10);
        apply_reset(1);
        run_sweep(0);
`else
        // Request in the very first cycle after reset.
        step(1'b1, 5'd9, 32'h0BAD_F00D, 1'b0, 5'd0, '0, ag, lg, ga, gl);
        check_eq("first_cycle_ready", ga, 1);
`endif

        // ALU alone.
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, '0, ag, lg, ga, gl);
        check_eq("alu_only_target", bus.target_reg, 5);
        check_eq("alu_only_data", bus.write_rd_data, 32'hDEAD_BEEF);
        // Idle: write drops, target/data hold.
        step(1'b0, 5'd7, 32'h1, 1'b0, 5'd8, 32'h2, ag, lg, ga, gl);
        check_eq("idle_hold_target", bus.target_reg, 5);

        // Both valid continuously: LSU x4 then ALU, repeating.
        ad = 32'hA000_0000;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 5'd7, ad, 1'b1, 5'd12, 32'hB000_0000 + i, ag, lg, ga, gl);
            check_eq("starve_pattern", ga, (i % 5) == 4);
            if (ag) ad = ad + 1;
        end

        // LSU write to x0 is accepted and dropped.
        step(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h1234, ag, lg, ga, gl);
        check_eq("x0_lsu_ready", gl, 1);
        check_eq("x0_write_reg", bus.write_reg, 0);

        // Random traffic; requesters hold their request until accepted.
        ap = 1'b0;
        lp = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!ap && $urandom_range(0, 2) != 0) begin
                ap  = 1'b1;
                ard = 5'($urandom);
                ad  = $urandom;
            end
            if (!lp && $urandom_range(0, 2) != 0) begin
                lp  = 1'b1;
                lrd = ($urandom_range(0, 3) == 0) ? ard : 5'($urandom);
                ld  = $urandom;
            end
            step(ap, ard, ad, lp, lrd, ld, ag, lg, ga, gl);
            if (ag) ap = 1'b0;
            if (lg) lp = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
